// File: rtl/inject_engine_if.sv
// inject_engine_if: port bundle between the ejection stage, local source and the injection stage
//   in_0..in_3        post-ejection flits (N/E/S/W), bit1=1 marks a free slot
//   inject_flit       local flit offered for injection
//   inj_bit           local push request, taken when injection_status=1
//   injection_status  FIFO-not-full ready
//   out_0..out_3      registered flits toward the routing stage
//   fifo_count        registered injection FIFO occupancy
interface inject_engine_if #(parameter int AW = 2);
  logic [31:0] in_0, in_1, in_2, in_3, inject_flit;
  logic inj_bit, injection_status;
  logic [31:0] out_0, out_1, out_2, out_3;
  logic [AW:0] fifo_count;
  modport master (
    output in_0, in_1, in_2, in_3, inject_flit, inj_bit,
    input  injection_status, out_0, out_1, out_2, out_3, fifo_count
  );
  modport slave (
    input  in_0, in_1, in_2, in_3, inject_flit, inj_bit,
    output injection_status, out_0, out_1, out_2, out_3, fifo_count
  );
endinterface

// File: rtl/inject_engine.sv
// inject_engine: queues local flits and drops the head into the lowest free router slot
//   clk  clock, rst asynchronous active-high reset
//   bus  inject_engine_if.slave (slot inputs, local push, registered slot outputs, occupancy)
module inject_engine #(
  parameter int          DEPTH      = 4,
  parameter int          AW         = 2,
  parameter logic [31:0] EMPTY_FLIT = 32'h0000_0002
) (
  input logic            clk,
  input logic            rst,
  inject_engine_if.slave bus
);
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   out_q [4];
  logic [31:0]   out_d [4];
  logic [31:0]   in_w [4];
  logic [31:0]   head, inj;
  logic [3:0]    free;
  logic [1:0]    sel;
  logic          push, pop;
  assign in_w[0] = bus.in_0;
  assign in_w[1] = bus.in_1;
  assign in_w[2] = bus.in_2;
  assign in_w[3] = bus.in_3;
  assign free = {in_w[3][1], in_w[2][1], in_w[1][1], in_w[0][1]};
  // ready depends only on the registered count, so a same-edge pop never frees room for a push
  assign bus.injection_status = cnt_q != (AW+1)'(DEPTH);
  assign push = bus.inj_bit & bus.injection_status;
  assign pop = (cnt_q != '0) & (|free);
  assign sel = free[0] ? 2'd0 : free[1] ? 2'd1 : free[2] ? 2'd2 : 2'd3;
  assign head = mem_q[rd_q];
  // injected flit claims the slot: free flag cleared, input-port field set to the slot index
  assign inj = {head[31:4], sel, 1'b0, head[0]};
  assign rd_d = rd_q + AW'(pop);
  assign wr_d = wr_q + AW'(push);
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  always_comb begin
    for (int k = 0; k < 4; k++) out_d[k] = (pop && sel == 2'(k)) ? inj : in_w[k];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < 4; k++) out_q[k] <= EMPTY_FLIT;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < 4; k++) out_q[k] <= out_d[k];
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.inject_flit;
  end
  assign bus.out_0 = out_q[0];
  assign bus.out_1 = out_q[1];
  assign bus.out_2 = out_q[2];
  assign bus.out_3 = out_q[3];
  assign bus.fifo_count = cnt_q;
endmodule

// File: tb/tb_inject_engine.sv
// tb_inject_engine: directed and random checks of inject_engine against a queue-based model
module tb_inject_engine;
  localparam logic [31:0] E = 32'h0000_0002;
  localparam logic [31:0] OCC = 32'h1109_008c;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  inject_engine_if #(.AW(2)) bus ();
  inject_engine #(.DEPTH(4), .AW(2), .EMPTY_FLIT(E)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];
  logic [31:0] exp_out [4];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, "_out0"}, bus.out_0, exp_out[0]);
    chk({tag, "_out1"}, bus.out_1, exp_out[1]);
    chk({tag, "_out2"}, bus.out_2, exp_out[2]);
    chk({tag, "_out3"}, bus.out_3, exp_out[3]);
    chk({tag, "_count"}, 32'(bus.fifo_count), 32'(q.size()));
    chk({tag, "_ready"}, 32'(bus.injection_status), 32'(q.size() < 4));
  endtask
  task automatic set_in(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    bus.in_0 = a; bus.in_1 = b; bus.in_2 = c; bus.in_3 = d;
  endtask
  // one clock edge: model decides from pre-edge inputs, then outputs are compared 1 time unit later
  task automatic cycle(input string tag, output bit accepted);
    logic [31:0] ins [4];
    logic [31:0] h;
    int slot;
    bit ready;
    ins[0] = bus.in_0; ins[1] = bus.in_1; ins[2] = bus.in_2; ins[3] = bus.in_3;
    ready = q.size() < 4;
    accepted = bus.inj_bit && ready;
    slot = -1;
    for (int i = 3; i >= 0; i--) if (ins[i][1]) slot = i;
    for (int i = 0; i < 4; i++) exp_out[i] = ins[i];
    if (q.size() > 0 && slot >= 0) begin
      h = q.pop_front();
      h[1] = 1'b0;
      h[3:2] = 2'(slot);
      exp_out[slot] = h;
    end
    if (accepted) q.push_back(bus.inject_flit);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  initial begin
    bit acc;
    logic [31:0] pend;
    rst = 1'b1;
    set_in(E, E, E, E);
    bus.inject_flit = '0;
    bus.inj_bit = 1'b0;
    for (int i = 0; i < 4; i++) exp_out[i] = E;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_held");
    rst = 1'b0;
    #1;
    check_all("reset_rel");
    // slot ordering: only east slot free
    set_in(OCC, 32'h0008_00c2, OCC, OCC);
    bus.inject_flit = 32'h0031_8551;
    bus.inj_bit = 1'b1;
    cycle("slot_e0", acc);
    chk("slot_e0_cnt1", 32'(bus.fifo_count), 32'd1);
    bus.inj_bit = 1'b0;
    cycle("slot_e1", acc);
    chk("slot_out1", bus.out_1, 32'h0031_8555);
    chk("slot_out0", bus.out_0, 32'h1109_008c);
    chk("slot_cnt0", 32'(bus.fifo_count), 32'd0);
    // priority: queue two flits with no free slot, then free all slots
    set_in(OCC, OCC, OCC, OCC);
    bus.inj_bit = 1'b1;
    bus.inject_flit = 32'h0031_8551;
    cycle("prio_q0", acc);
    bus.inject_flit = 32'h0031_8561;
    cycle("prio_q1", acc);
    bus.inj_bit = 1'b0;
    set_in(E, E, E, E);
    cycle("prio_d0", acc);
    chk("prio_d0_out0", bus.out_0, 32'h0031_8551);
    chk("prio_d0_out1", bus.out_1, E);
    cycle("prio_d1", acc);
    chk("prio_d1_out0", bus.out_0, 32'h0031_8561);
    chk("prio_d1_cnt", 32'(bus.fifo_count), 32'd0);
    // no free slot: fill the FIFO, extra requests refused
    set_in(OCC, OCC, OCC, OCC);
    bus.inj_bit = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.inject_flit = 32'h0031_8551 + (k << 20);
      cycle("nofree", acc);
      chk("nofree_acc", 32'(acc), 32'(k < 4));
    end
    chk("nofree_full", 32'(bus.injection_status), 32'd0);
    chk("nofree_cnt4", 32'(bus.fifo_count), 32'd4);
    // full with pop on west slot: push refused this edge, accepted next edge
    set_in(OCC, OCC, OCC, E);
    bus.inject_flit = 32'h0071_8551;
    cycle("full_pop", acc);
    chk("full_out3", bus.out_3, 32'h0031_855d);
    chk("full_cnt3", 32'(bus.fifo_count), 32'd3);
    chk("full_refused", 32'(acc), 32'd0);
    set_in(OCC, OCC, OCC, OCC);
    cycle("full_next", acc);
    chk("full_next_acc", 32'(acc), 32'd1);
    // leave 3 queued, then reset asynchronously between edges
    bus.inj_bit = 1'b0;
    set_in(E, OCC, OCC, OCC);
    cycle("pre_rst", acc);
    chk("pre_rst_cnt3", 32'(bus.fifo_count), 32'd3);
    #3;
    rst = 1'b1;
    #1;
    q.delete();
    for (int i = 0; i < 4; i++) exp_out[i] = E;
    check_all("async_rst");
    #2;
    rst = 1'b0;
    set_in(E, E, E, E);
    for (int k = 0; k < 4; k++) cycle("post_rst", acc);
    // randomized traffic; a refused flit is held until accepted
    pend = $urandom;
    bus.inj_bit = 1'b0;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] r [4];
      for (int i = 0; i < 4; i++) begin
        r[i] = $urandom;
        r[i][1] = ($urandom_range(0, 2) == 0);
      end
      set_in(r[0], r[1], r[2], r[3]);
      if (!bus.inj_bit) bus.inj_bit = ($urandom_range(0, 1) == 1);
      bus.inject_flit = pend;
      cycle("rand", acc);
      if (acc) begin
        pend = $urandom;
        bus.inj_bit = 1'b0;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inject_engine.md
Name: inject_engine

Overview:
- Local-side injection stage of the bufferless deflection router. It sits directly after the ejection stage.
- Takes the four post-ejection port flits. A flit with bit 1 (ejected flag) = 1 marks a free slot.
- Queues locally generated flits in a small FIFO and drops the head flit into the lowest-indexed free slot.
- Registers the four port flits toward the permutation/routing stage.

Parameters:
- DEPTH, 4, injection FIFO depth in flits (power of 2, ≥2)
- AW, 2, FIFO pointer width = log2(DEPTH)
- EMPTY_FLIT, 32'h00000002, value driven for an empty slot (bit1=1, all else 0)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_0  input  32  post-ejection flit, north slot
- in_1  input  32  post-ejection flit, east slot
- in_2  input  32  post-ejection flit, south slot
- in_3  input  32  post-ejection flit, west slot
- inject_flit  input  32  local flit offered for injection
- inj_bit  input  1  local request; flit pushed when inj_bit & injection_status
- injection_status  output  1  ready: 1 when FIFO not full (from registered count only)
- out_0  output  32  registered north slot flit
- out_1  output  32  registered east slot flit
- out_2  output  32  registered south slot flit
- out_3  output  32  registered west slot flit
- fifo_count  output  AW+1  registered FIFO occupancy, 0..DEPTH

Behaviour:
- Flit fields:
  - bit0 golden
  - bit1 ejected/free
  - [3:2] input port (00 N, 01 E, 10 S, 11 W)
  - [6:4] output port
  - [10:7] source
  - [14:11] destination
  - [19:15] sequence
  - [31:20] untouched
- Reset (rst=1, asynchronous): out_0..out_3 = EMPTY_FLIT; fifo_count = 0; read/write pointers = 0; injection_status = 1 after reset.
- Reset mid-operation discards all queued flits. No partial output.
- Push: at an edge where inj_bit=1 and injection_status=1, inject_flit is written at the write pointer and the write pointer increments mod DEPTH.
- inj_bit while full: the flit is ignored, and the source must hold it.
- Free-slot detect (combinational): free_i = in_i[1].
- Selection: if FIFO is non-empty and any free_i is set, pick the lowest i with free_i=1 (priority 0>1>2>3).
- On that edge:
  - out_i = head flit with bit1 forced 0 and [3:2] forced to i.
  - Bits 0, [31:4] are copied unchanged, including golden and sequence.
  - The read pointer increments mod DEPTH.
- Non-selected slots: out_j = in_j registered unchanged, including still-free slots, which keep bit1=1.
- At most one injection per cycle, even with multiple free slots.
- No free slot: the head waits and all four inputs pass through registered. No starvation limit; the router guarantees eventual ejection.
- No bypass: a flit pushed at edge E0 is visible as head after E0. The earliest edge it can be registered onto an output is E1.
  - Minimum accept-to-output latency is 2 edges; pass-through latency is 1 edge.
- Simultaneous push and pop: both occur. fifo_count unchanged.
  - Ready is computed from the pre-edge count, so a push is refused at full even if a pop occurs on the same edge.
- Pointer wrap: pointers wrap DEPTH-1 → 0. Full/empty are derived from fifo_count, not pointer equality.
- fifo_count: +1 on push only, −1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- The FIFO preserves local flit order, so in-packet sequence order at injection is maintained.

Test Plan:
- Reset → after rst high then low: out_0..out_3 = 32'h00000002, fifo_count=0, injection_status=1.
- Slot ordering:
  - Stimulus: in_0=32'h1109008c (occupied), in_1=32'h000800c2 (free), in_2=in_3 occupied. Push inject_flit=32'h00318551 at E0.
  - Required: fifo_count=1 after E0; out_1=32'h00318555 after E1 (port bits 01, bit1=0); out_0=32'h1109008c; fifo_count=0.
- Priority with all slots free:
  - Stimulus: in_0..in_3=32'h00000002, two flits queued.
  - Required: each cycle only out_0 takes the head (32'h00318551 form), out_1..out_3 = 32'h00000002; FIFO drains in 2 cycles in push order.
- No free slot:
  - Stimulus: all inputs bit1=0 (32'h1109008c) for 6 cycles, inj_bit held high.
  - Required: outputs equal the inputs with 1-edge delay; fifo_count reaches 4; injection_status=0; further flits are not accepted.
- Full with simultaneous event:
  - Stimulus: at fifo_count=4, free slot in_3 and inj_bit=1.
  - Required: pop to out_3 with [3:2]=11 (e.g. 32'h00318551 → 32'h0031855d); push refused; count=3; the next edge accepts the push.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously with 3 queued flits.
  - Required: outputs go to 32'h00000002 immediately (no clock edge), fifo_count=0; the old flits never appear after release.
